// File: rtl/spi_flash_rd_ctrl_if.sv
// Request/response bus between a word-read client and spi_flash_rd_ctrl.
// The master issues read requests and the slave answers with one word each.
interface spi_flash_rd_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/spi_flash_rd_ctrl.sv
// Turns one word-read request into a SPI flash READ (0x03 + 24-bit address + 32
// data bits, mode 0) and returns the word with the first flash byte in [7:0].
module spi_flash_rd_ctrl #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned SS_WIDTH = 8,
  parameter int unsigned CS_IDX   = 0
) (
  input  logic                clock,
  input  logic                reset,
  spi_flash_rd_ctrl_if.slave  bus,
  output logic                flash_sck,
  output logic [SS_WIDTH-1:0] flash_ss,
  output logic                flash_mosi,
  input  logic                flash_miso
);

  localparam int unsigned HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic          phase_q, phase_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [31:0]   tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_data_q, rsp_data_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      half_q      <= '0;
      phase_q     <= 1'b0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          tx_d      = {8'h03, bus.req_addr};
          half_d    = '0;
          phase_d   = 1'b0;
          bit_cnt_d = '0;
          state_d   = XFER;
        end
      end

      XFER: begin
        if (half_q != HALF_LAST) begin
          half_d = half_q + 1'b1;
        end else begin
          half_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // Bit end: miso sampled in the last high cycle, only for the data half.
            phase_d   = 1'b0;
            tx_d      = {tx_q[30:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q[5]) begin
              rx_d = {rx_q[30:0], flash_miso};
            end
            if (bit_cnt_q == 6'd63) begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = {rx_d[7:0], rx_d[15:8], rx_d[23:16], rx_d[31:24]};
              state_d     = GAP;
            end
          end
        end
      end

      GAP: begin
        if (half_q == HALF_LAST) begin
          half_d  = '0;
          state_d = IDLE;
        end else begin
          half_d = half_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flash_ss         = '1;
    flash_ss[CS_IDX] = (state_q != XFER);
  end

  assign flash_sck     = (state_q == XFER) & phase_q;
  assign flash_mosi    = (state_q == XFER) & tx_q[31];
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Directed bench for spi_flash_rd_ctrl: one instance at CLK_DIV=2, one at
// CLK_DIV=1, each driven by a simple SPI flash model.
module tb_spi_flash_rd_ctrl;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_flash_rd_ctrl_if if2 ();
  spi_flash_rd_ctrl_if if1 ();

  logic [1:0]  req_valid_r;
  logic [23:0] req_addr_r [2];
  logic [1:0]  miso_r;
  logic [31:0] flash_word [2];

  logic       sck0, sck1, mosi0, mosi1;
  logic [7:0] ss0, ss1;

  assign if2.req_valid = req_valid_r[0];
  assign if2.req_addr  = req_addr_r[0];
  assign if1.req_valid = req_valid_r[1];
  assign if1.req_addr  = req_addr_r[1];

  spi_flash_rd_ctrl #(.CLK_DIV(2), .SS_WIDTH(8), .CS_IDX(0)) dut2 (
    .clock      (clk),
    .reset      (rst),
    .bus        (if2),
    .flash_sck  (sck0),
    .flash_ss   (ss0),
    .flash_mosi (mosi0),
    .flash_miso (miso_r[0])
  );

  spi_flash_rd_ctrl #(.CLK_DIV(1), .SS_WIDTH(8), .CS_IDX(0)) dut1 (
    .clock      (clk),
    .reset      (rst),
    .bus        (if1),
    .flash_sck  (sck1),
    .flash_ss   (ss1),
    .flash_mosi (mosi1),
    .flash_miso (miso_r[1])
  );

  logic [1:0]  sck_w, mosi_w, ready_w, rspv_w;
  logic [7:0]  ss_w   [2];
  logic [31:0] rspd_w [2];

  assign sck_w   = {sck1, sck0};
  assign mosi_w  = {mosi1, mosi0};
  assign ready_w = {if1.req_ready, if2.req_ready};
  assign rspv_w  = {if1.rsp_valid, if2.rsp_valid};
  assign ss_w[0] = ss0;
  assign ss_w[1] = ss1;
  assign rspd_w[0] = if2.rsp_data;
  assign rspd_w[1] = if1.rsp_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Flash model and pin monitor, sampled mid-cycle.
  logic [1:0]  sck_prev, ss_prev, mosi_prev;
  int          edges      [2];
  int          last_edges [2];
  logic [31:0] cmd_cap    [2];

  initial begin
    miso_r = 2'b11;
    for (int i = 0; i < 2; i++) begin
      edges[i] = 0;
      last_edges[i] = 0;
      cmd_cap[i] = '0;
    end
    sck_prev = '0;
    ss_prev = 2'b11;
    mosi_prev = '0;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("ss_others_high", 64'(ss_w[i][7:1]), 64'h7F);
        chk("sck_while_deselected", 64'(sck_w[i] & ss_w[i][0]), 64'd0);
        if (!ss_w[i][0] && sck_w[i] && !sck_prev[i]) begin
          if (!ss_prev[i]) chk("mosi_stable_over_rise", 64'(mosi_w[i]), 64'(mosi_prev[i]));
          if (edges[i] < 32) cmd_cap[i] = {cmd_cap[i][30:0], mosi_w[i]};
          if (edges[i] >= 32 && edges[i] < 64) miso_r[i] = flash_word[i][63 - edges[i]];
          else miso_r[i] = 1'b1;
          edges[i]++;
        end
        if (ss_w[i][0] && !ss_prev[i]) begin
          last_edges[i] = edges[i];
          edges[i] = 0;
        end
        sck_prev[i]  = sck_w[i];
        ss_prev[i]   = ss_w[i][0];
        mosi_prev[i] = mosi_w[i];
      end
    end
  end

  task automatic wait_hs(input int i, output int t);
    int n;
    for (n = 0; n < 600; n++) begin
      if (ready_w[i] && req_valid_r[i]) break;
      @(negedge clk);
    end
    if (n == 600) chk("handshake_timeout", 64'd1, 64'd0);
    t = cyc;
  endtask

  task automatic wait_rsp(input int i, output int t);
    int n;
    for (n = 0; n < 600; n++) begin
      if (rspv_w[i]) break;
      @(negedge clk);
    end
    if (n == 600) chk("rsp_timeout", 64'd1, 64'd0);
    t = cyc;
  endtask

  task automatic single(input int i, input logic [23:0] addr, input logic [31:0] word,
                        input logic [31:0] exp, input int lat);
    int t, tr;
    flash_word[i] = word;
    req_addr_r[i] = addr;
    req_valid_r[i] = 1'b1;
    wait_hs(i, t);
    @(negedge clk);
    req_valid_r[i] = 1'b0;
    chk("ready_low_after_hs", 64'(ready_w[i]), 64'd0);
    chk("ss_low_in_xfer", 64'(ss_w[i]), 64'hFE);
    wait_rsp(i, tr);
    chk("rsp_latency", 64'(tr - t), 64'(lat));
    chk("rsp_data", 64'(rspd_w[i]), 64'(exp));
    chk("cmd_addr_bits", 64'(cmd_cap[i]), 64'({8'h03, addr}));
    @(negedge clk);
    chk("rsp_one_cycle", 64'(rspv_w[i]), 64'd0);
    chk("rsp_data_hold", 64'(rspd_w[i]), 64'(exp));
    chk("sck_rise_count", 64'(last_edges[i]), 64'd64);
  endtask

  initial begin
    int t1, t2, r1, r2, n_rsp;
    rst = 1'b1;
    req_valid_r = '0;
    req_addr_r[0] = '0;
    req_addr_r[1] = '0;
    flash_word[0] = '0;
    flash_word[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(ready_w[0]), 64'd1);
    chk("reset_rsp_valid", 64'(rspv_w[0]), 64'd0);
    chk("reset_rsp_data", 64'(rspd_w[0]), 64'd0);
    chk("reset_sck", 64'(sck_w[0]), 64'd0);
    chk("reset_ss", 64'(ss_w[0]), 64'hFF);
    chk("reset_mosi", 64'(mosi_w[0]), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    single(0, 24'h001234, 32'hDEADBEEF, 32'hEFBEADDE, 257);
    single(1, 24'hABCDEF, 32'h11223344, 32'h44332211, 129);

    // Back-to-back with req_valid held; second address exercises the top of the map.
    flash_word[0] = 32'h01234567;
    req_addr_r[0] = 24'h00FFFE;
    req_valid_r[0] = 1'b1;
    wait_hs(0, t1);
    @(negedge clk);
    req_addr_r[0] = 24'hFFFFFF;
    wait_rsp(0, r1);
    chk("b2b_rsp1_latency", 64'(r1 - t1), 64'd257);
    chk("b2b_rsp1_data", 64'(rspd_w[0]), 64'h67452301);
    chk("b2b_cmd1", 64'(cmd_cap[0]), 64'h0300FFFE);
    flash_word[0] = 32'hA5C30F96;
    @(negedge clk);
    chk("gap_ss_high", 64'(ss_w[0]), 64'hFF);
    chk("gap_not_ready", 64'(ready_w[0]), 64'd0);
    wait_hs(0, t2);
    chk("b2b_hs_spacing", 64'(t2 - t1), 64'd259);
    @(negedge clk);
    req_valid_r[0] = 1'b0;
    wait_rsp(0, r2);
    chk("b2b_rsp2_latency", 64'(r2 - t2), 64'd257);
    chk("b2b_rsp2_data", 64'(rspd_w[0]), 64'h960FC3A5);
    chk("b2b_cmd2", 64'(cmd_cap[0]), 64'h03FFFFFF);
    repeat (4) @(negedge clk);

    // Address and valid churn while busy must not disturb the latched request.
    flash_word[0] = 32'hCAFEF00D;
    req_addr_r[0] = 24'h5A5A5A;
    req_valid_r[0] = 1'b1;
    wait_hs(0, t1);
    for (int n = 0; n < 250; n++) begin
      @(negedge clk);
      req_addr_r[0] = 24'($urandom);
      req_valid_r[0] = n[0];
    end
    req_valid_r[0] = 1'b0;
    wait_rsp(0, r1);
    chk("busy_churn_latency", 64'(r1 - t1), 64'd257);
    chk("busy_churn_data", 64'(rspd_w[0]), 64'h0DF0FECA);
    chk("busy_churn_cmd", 64'(cmd_cap[0]), 64'h035A5A5A);
    repeat (10) @(negedge clk);
    chk("no_extra_xfer_ready", 64'(ready_w[0]), 64'd1);
    chk("no_extra_xfer_ss", 64'(ss_w[0]), 64'hFF);

    // Reset in the middle of a transfer.
    flash_word[0] = 32'h55AA55AA;
    req_addr_r[0] = 24'h000100;
    req_valid_r[0] = 1'b1;
    wait_hs(0, t1);
    @(negedge clk);
    req_valid_r[0] = 1'b0;
    repeat (100) @(negedge clk);
    chk("pre_reset_selected", 64'(ss_w[0]), 64'hFE);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_ss", 64'(ss_w[0]), 64'hFF);
    chk("midreset_sck", 64'(sck_w[0]), 64'd0);
    chk("midreset_ready", 64'(ready_w[0]), 64'd1);
    chk("midreset_mosi", 64'(mosi_w[0]), 64'd0);
    chk("midreset_rsp_data", 64'(rspd_w[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_rsp = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rspv_w[0]) n_rsp++;
    end
    chk("no_rsp_after_reset", 64'(n_rsp), 64'd0);
    chk("idle_after_reset", 64'(ready_w[0]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
